// File: rtl/downsample_stream_pkg.sv
// Shared types and defaults for the stream decimator: mode encodings and default widths.
package downsample_stream_pkg;

    typedef enum logic {
        DsModePick = 1'b0,
        DsModeAvg  = 1'b1
    } ds_mode_e;

    localparam int unsigned DsDefaultDw      = 14;
    localparam int unsigned DsDefaultLogmMax = 6;

endpackage

// File: rtl/ds_accum.sv
// Window counter and accumulator: produces a one-cycle completion strobe together with the
// combinational window result (last sample or floor mean).
module ds_accum
    import downsample_stream_pkg::*;
#(
    parameter int unsigned DW       = DsDefaultDw,
    parameter int unsigned LOGM_MAX = DsDefaultLogmMax
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               restart_i,
    input  logic                               mode_i,
    input  logic [$clog2(LOGM_MAX+1)-1:0]      rate_log2_i,
    input  logic                               s_valid_i,
    input  logic [DW-1:0]                      s_data_i,
    output logic                               done_o,
    output logic [DW-1:0]                      result_o
);

    localparam int unsigned RW = $clog2(LOGM_MAX + 1);
    localparam int unsigned AW = DW + LOGM_MAX;
    localparam int unsigned CW = (LOGM_MAX > 0) ? LOGM_MAX : 1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    ds_mode_e             mode_q, mode_d;
    logic [RW-1:0]        log2_q, log2_d;

    logic                 first, accept, last;
    logic [RW-1:0]        rate_clamped, eff_log2;
    ds_mode_e             eff_mode;
    logic [CW:0]          last_idx;
    logic signed [AW-1:0] data_ext, acc_sum, avg;

    // The first sample of a window sees the live controls, later ones the latched copies.
    always_comb begin
        rate_clamped = (32'(rate_log2_i) > LOGM_MAX) ? RW'(LOGM_MAX) : rate_log2_i;
        first        = (cnt_q == '0);
        eff_mode     = first ? ds_mode_e'(mode_i) : mode_q;
        eff_log2     = first ? rate_clamped : log2_q;
        last_idx     = ((CW+1)'(1) << eff_log2) - (CW+1)'(1);
        accept       = s_valid_i & ~restart_i;
        data_ext     = AW'($signed(s_data_i));
        acc_sum      = first ? data_ext : acc_q + data_ext;
        avg          = acc_sum >>> eff_log2;
        last         = accept & ({1'b0, cnt_q} == last_idx);
        done_o       = last;
        result_o     = (eff_mode == DsModeAvg) ? avg[DW-1:0] : s_data_i;
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mode_d = mode_q;
        log2_d = log2_q;
        if (restart_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_sum;
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (first) begin
                mode_d = eff_mode;
                log2_d = rate_clamped;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            mode_q <= DsModePick;
            log2_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mode_q <= mode_d;
            log2_q <= log2_d;
        end
    end

endmodule

// File: rtl/downsample_stream.sv
// Decimating stream stage: pick or boxcar-average over 2^rate_log2_i samples, with a
// one-deep output register, ready/valid handshake and sticky drop flag.
module downsample_stream
    import downsample_stream_pkg::*;
#(
    parameter int unsigned DW       = DsDefaultDw,
    parameter int unsigned LOGM_MAX = DsDefaultLogmMax
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               restart_i,
    input  logic                               mode_i,
    input  logic [$clog2(LOGM_MAX+1)-1:0]      rate_log2_i,
    input  logic                               s_valid_i,
    input  logic [DW-1:0]                      s_data_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [DW-1:0]                      m_data_o,
    output logic                               ovf_o,
    input  logic                               ovf_clr_i
);

    logic          done;
    logic [DW-1:0] result;
    logic          drop;

    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          ovf_q, ovf_d;

    ds_accum #(
        .DW       (DW),
        .LOGM_MAX (LOGM_MAX)
    ) u_accum (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .restart_i   (restart_i),
        .mode_i      (mode_i),
        .rate_log2_i (rate_log2_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .done_o      (done),
        .result_o    (result)
    );

    // A result arriving while the held one is not being taken is lost.
    assign drop = done & m_valid_q & ~m_ready_i;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        ovf_d     = ovf_q;
        if (done && !drop) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
        end else if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_downsample_stream.sv
// Scoreboard bench for downsample_stream: a behavioural window model queues expected outputs,
// a negedge monitor pops and compares them on every handshake.
module tb_downsample_stream;

    localparam int unsigned DW       = 14;
    localparam int unsigned LOGM_MAX = 6;
    localparam int unsigned RW       = $clog2(LOGM_MAX + 1);

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          restart_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [RW-1:0] rate_log2_i = '0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
    logic [DW-1:0] m_data_o;
    logic          ovf_o;
    logic          ovf_clr_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int            mc = 0;
    longint        macc = 0;
    logic          mmode = 1'b0;
    int            mlog2 = 0;
    logic          exp_valid = 1'b0;
    logic          exp_ovf = 1'b0;

    downsample_stream #(
        .DW       (DW),
        .LOGM_MAX (LOGM_MAX)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .restart_i   (restart_i),
        .mode_i      (mode_i),
        .rate_log2_i (rate_log2_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Handshake completes at the next posedge; inputs are stable at the negedge.
    always @(negedge clk_i) begin
        if (rst_n_i && m_valid_o && m_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0d want none at %0t",
                         $signed(m_data_o), $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_data_o !== e) begin
                    errors++;
                    $display("FAIL m_data: got %0d want %0d at %0t",
                             $signed(m_data_o), $signed(e), $time);
                end
            end
        end
    end

    task automatic cycle(input logic v, input logic signed [DW-1:0] d, input logic rs,
                         input logic clr);
        logic          done;
        logic          drop;
        logic [DW-1:0] res;
        longint        sh;
        longint        dl;
        s_valid_i = v;
        s_data_i  = d;
        restart_i = rs;
        ovf_clr_i = clr;
        @(posedge clk_i);
        done = 1'b0;
        res  = '0;
        dl   = d;
        if (rs) begin
            mc   = 0;
            macc = 0;
        end else if (v) begin
            if (mc == 0) begin
                mmode = mode_i;
                mlog2 = (int'(rate_log2_i) > LOGM_MAX) ? LOGM_MAX : int'(rate_log2_i);
                macc  = dl;
            end else begin
                macc = macc + dl;
            end
            if (mc == (1 << mlog2) - 1) begin
                done = 1'b1;
                sh   = macc >>> mlog2;
                res  = mmode ? sh[DW-1:0] : d;
                mc   = 0;
            end else begin
                mc++;
            end
        end
        drop = done && exp_valid && !m_ready_i;
        if (done && !drop) exp_q.push_back(res);
        exp_valid = done ? 1'b1 : (m_ready_i ? 1'b0 : exp_valid);
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        #1;
        checks++;
        if (m_valid_o !== exp_valid) begin
            errors++;
            $display("FAIL m_valid: got %0b want %0b at %0t", m_valid_o, exp_valid, $time);
        end
        checks++;
        if (ovf_o !== exp_ovf) begin
            errors++;
            $display("FAIL ovf: got %0b want %0b at %0t", ovf_o, exp_ovf, $time);
        end
        s_valid_i = 1'b0;
        restart_i = 1'b0;
        ovf_clr_i = 1'b0;
    endtask

    task automatic send(input logic signed [DW-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        #1;
        exp_q.delete();
        mc        = 0;
        macc      = 0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b want 0", m_valid_o);
        end
        checks++;
        if (m_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0d want 0", $signed(m_data_o));
        end
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %0b want 0", ovf_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        idle();
    endtask

    task automatic test_pick();
        mode_i      = 1'b0;
        rate_log2_i = RW'(2);
        for (int i = 0; i < 12; i++) send(DW'(i));
        idle();
    endtask

    task automatic test_avg();
        mode_i      = 1'b1;
        rate_log2_i = RW'(2);
        send(14'sd4);
        send(14'sd5);
        idle();
        idle();
        send(-14'sd3);
        send(-14'sd7);
        send(14'sd1);
        send(14'sd1);
        send(14'sd1);
        send(14'sd2);
        idle();
    endtask

    task automatic test_back_to_back();
        rate_log2_i = '0;
        mode_i      = 1'b1;
        send(-14'sd5);
        send(14'sd7);
        send(-14'sd8192);
        mode_i = 1'b0;
        send(14'sd8191);
        send(-14'sd1);
        idle();
    endtask

    task automatic test_overflow();
        mode_i      = 1'b0;
        rate_log2_i = RW'(1);
        m_ready_i   = 1'b0;
        send(14'sd10);
        send(14'sd20);
        send(14'sd30);
        send(14'sd40);
        idle();
        checks++;
        if (m_data_o !== 14'd20) begin
            errors++;
            $display("FAIL ovf_hold_data: got %0d want 20", $signed(m_data_o));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        send(14'sd50);
        cycle(1'b1, 14'sd60, 1'b0, 1'b1);
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %0b want 1", ovf_o);
        end
        m_ready_i = 1'b1;
        idle();
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_rate_change();
        mode_i      = 1'b0;
        rate_log2_i = RW'(2);
        send(14'sd1);
        send(14'sd2);
        rate_log2_i = RW'(1);
        send(14'sd3);
        send(14'sd4);
        send(14'sd5);
        send(14'sd6);
        idle();
    endtask

    task automatic test_restart();
        mode_i      = 1'b1;
        rate_log2_i = RW'(2);
        send(14'sd100);
        send(14'sd100);
        send(14'sd100);
        cycle(1'b1, 14'sd100, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(14'sd8);
        idle();
        send(14'sd100);
        send(14'sd100);
        send(14'sd100);
        apply_reset();
        mode_i      = 1'b1;
        rate_log2_i = RW'(2);
        for (int i = 0; i < 4; i++) send(14'sd8);
        idle();
    endtask

    task automatic test_clamp();
        mode_i      = 1'b1;
        rate_log2_i = RW'(LOGM_MAX + 1);
        for (int i = 0; i < 128; i++) send(DW'(i * 97 - 3000));
        idle();
        mode_i = 1'b0;
        for (int i = 0; i < 64; i++) send(DW'(i * 13 + 5));
        idle();
    endtask

    initial begin
        #1;
        test_reset();
        test_pick();
        test_avg();
        test_back_to_back();
        test_overflow();
        test_rate_change();
        test_restart();
        test_clamp();
        m_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
